// File: rtl/spi_keyboard_responder_pkg.sv
// Constants shared by the keyboard-side SPI responder and the bus controller.
// A byte value of 0x00 always means "no key event".
package spi_keyboard_responder_pkg;

    localparam logic [7:0] KEY_NO_EVENT      = 8'h00;
    localparam int         SPI_MODE          = 0;
    localparam int         MIN_HALF_BIT_CLKS = 4;

    function automatic logic is_key_event(input logic [7:0] key_byte);
        return key_byte != KEY_NO_EVENT;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous byte FIFO for key events. The head is read combinationally, so a
// pushed byte becomes visible one cycle after the push edge.
module key_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ready_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next != CW'(DEPTH));
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign ready = ready_reg;
    assign count = count_reg;

endmodule

// File: rtl/spi_keyboard_responder.sv
// SPI mode-0 slave on the keyboard chip select: streams buffered key events out
// on MISO (0x00 when none pending) and reports each received MOSI byte.
module spi_keyboard_responder
    import spi_keyboard_responder_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IDLE_BYTE  = KEY_NO_EVENT
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_SPI_Clk,
    input  logic                          i_SPI_MOSI,
    input  logic                          i_SPI_CS_n,
    output logic                          o_SPI_MISO,
    input  logic [7:0]                    i_Key_Byte,
    input  logic                          i_Key_Valid,
    output logic                          o_Key_Ready,
    output logic [7:0]                    o_RX_Byte,
    output logic                          o_RX_DV,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Overflow
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [2:0] sclk_sync_reg;
    logic [2:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;

    logic [0:0] state_reg;
    logic [7:0] tx_reg;
    logic [7:0] rx_shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       loaded_reg;
    logic       reload_reg;
    logic       miso_reg;
    logic [7:0] rx_byte_reg;
    logic       rx_dv_reg;
    logic       overflow_reg;

    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [7:0] rx_next;
    logic [7:0] fifo_head;
    logic [7:0] load_byte;
    logic       fifo_empty, fifo_full, fifo_pop, push_req, byte_done;

    // CS_n resets high so leaving reset never looks like a chip-select fall.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sclk_sync_reg <= 3'b000;
            cs_sync_reg   <= 3'b111;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], i_SPI_Clk};
            cs_sync_reg   <= {cs_sync_reg[1:0], i_SPI_CS_n};
            mosi_sync_reg <= {mosi_sync_reg[0], i_SPI_MOSI};
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
    assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2];
    assign cs_rise   = cs_sync_reg[1] & ~cs_sync_reg[2];
    assign rx_next   = {rx_shift_reg[6:0], mosi_sync_reg[1]};

    assign load_byte = fifo_empty ? IDLE_BYTE : fifo_head;
    assign push_req  = i_Key_Valid && is_key_event(i_Key_Byte);
    assign byte_done = (state_reg == ST_ACTIVE) && !cs_rise && sclk_rise && (bit_cnt_reg == 3'd7);
    // Only a byte that really came from the FIFO may pop it.
    assign fifo_pop  = byte_done && loaded_reg;

    key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_Clk),
        .srst  (i_Reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (i_Key_Byte),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .ready (o_Key_Ready),
        .count (o_Count)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            overflow_reg <= 1'b0;
        else if (push_req && fifo_full && !fifo_pop)
            overflow_reg <= 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg    <= ST_IDLE;
            tx_reg       <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            loaded_reg   <= 1'b0;
            reload_reg   <= 1'b0;
            miso_reg     <= 1'b0;
            rx_byte_reg  <= '0;
            rx_dv_reg    <= 1'b0;
        end else begin
            rx_dv_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    miso_reg <= 1'b0;
                    if (cs_fall) begin
                        state_reg   <= ST_ACTIVE;
                        tx_reg      <= load_byte;
                        miso_reg    <= load_byte[7];
                        loaded_reg  <= !fifo_empty;
                        bit_cnt_reg <= '0;
                        reload_reg  <= 1'b0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        // Partial bytes are dropped: no strobe, no pop.
                        state_reg   <= ST_IDLE;
                        miso_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                        reload_reg  <= 1'b0;
                        loaded_reg  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= rx_next;
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_byte_reg <= rx_next;
                            rx_dv_reg   <= 1'b1;
                            reload_reg  <= 1'b1;
                            loaded_reg  <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        if (reload_reg) begin
                            tx_reg     <= load_byte;
                            miso_reg   <= load_byte[7];
                            loaded_reg <= !fifo_empty;
                            reload_reg <= 1'b0;
                        end else if (bit_cnt_reg != 3'd0) begin
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                            miso_reg <= tx_reg[6];
                        end
                    end
                end
            endcase
        end
    end

    assign o_SPI_MISO = miso_reg;
    assign o_RX_Byte  = rx_byte_reg;
    assign o_RX_DV    = rx_dv_reg;
    assign o_Overflow = overflow_reg;

endmodule

// File: tb/tb_spi_keyboard_responder.sv
// Scoreboard bench: the stimulus thread predicts MISO/RX bytes from a queue model
// of the key FIFO; independent monitors compare what the DUT actually presents.
`timescale 1ns/1ps
module tb_spi_keyboard_responder;
    localparam int DEPTH = 8;
    localparam int HALF  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       miso;
    logic [7:0] key_byte = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic [3:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];

    always #5 clk = ~clk;

    spi_keyboard_responder #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'h00)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_SPI_Clk  (spi_clk),
        .i_SPI_MOSI (spi_mosi),
        .i_SPI_CS_n (spi_cs_n),
        .o_SPI_MISO (miso),
        .i_Key_Byte (key_byte),
        .i_Key_Valid(key_valid),
        .o_Key_Ready(key_ready),
        .o_RX_Byte  (rx_byte),
        .o_RX_DV    (rx_dv),
        .o_Count    (count),
        .o_Overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (b != 8'h00) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] b);
        @(negedge clk);
        key_byte  = b;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        model_push(b);
        $display("push %02h -> model occupancy %0d", b, model_q.size());
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},    32'(count),     32'(model_q.size()));
        check({tag, ".overflow"}, 32'(overflow),  32'(model_ovf));
        check({tag, ".ready"},    32'(key_ready), 32'(model_q.size() != DEPTH));
        if (spi_cs_n) check({tag, ".miso_idle"}, 32'(miso), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_clk  = 1'b0;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // nbits < 8 models an aborted byte; conc pushes cb in the cycle of the 8th-rise pop.
    task automatic spi_byte(input logic [7:0] m, input int nbits, input bit conc, input logic [7:0] cb);
        logic [7:0] exp;
        bit         loaded;
        loaded = (model_q.size() > 0);
        exp    = loaded ? model_q[0] : 8'h00;
        if (nbits == 8) begin
            exp_miso_q.push_back(exp);
            exp_rx_q.push_back(m);
        end
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = m[i];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (conc && i == 0 && k == 2) begin
                    key_byte  = cb;
                    key_valid = 1'b1;
                end
                if (conc && i == 0 && k == 3) key_valid = 1'b0;
            end
            spi_clk = 1'b0;
        end
        if (nbits == 8) begin
            if (loaded) void'(model_q.pop_front());
            if (conc) model_push(cb);
        end
    endtask

    // RX strobe monitor
    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            if (exp_rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_dv_unexpected: got strobe with byte %02h, expected none", rx_byte);
            end else begin
                logic [7:0] e;
                e = exp_rx_q.pop_front();
                check("rx_byte", 32'(rx_byte), 32'(e));
                $display("rx byte %02h (expected %02h)", rx_byte, e);
            end
        end
    end

    // MISO bus monitor: assembles bytes at SCLK rises inside a CS window
    int         mbits = 0;
    logic [7:0] mbyte = 8'h00;
    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mbits = 0;
        end else begin
            mbyte = {mbyte[6:0], miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got byte %02h, expected none", mbyte);
                end else begin
                    logic [7:0] e;
                    e = exp_miso_q.pop_front();
                    check("miso_byte", 32'(mbyte), 32'(e));
                    $display("miso byte %02h (expected %02h)", mbyte, e);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset.miso",     32'(miso),      32'd0);
        check("reset.rx_byte",  32'(rx_byte),   32'd0);
        check("reset.rx_dv",    32'(rx_dv),     32'd0);
        check("reset.ready",    32'(key_ready), 32'd1);
        check("reset.count",    32'(count),     32'd0);
        check("reset.overflow", 32'(overflow),  32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Idle read
        cs_low();
        spi_byte(8'hA5, 8, 1'b0, 8'h00);
        cs_high();
        check_state("idle_read");

        // Single event, two-byte window
        push_key(8'h1C);
        check_state("single_push");
        cs_low();
        spi_byte(8'h3E, 8, 1'b0, 8'h00);
        spi_byte(8'hC1, 8, 1'b0, 8'h00);
        cs_high();
        check_state("single_read");

        // Fill and overflow
        for (int b = 1; b <= 9; b++) begin
            push_key(8'(b));
            if (b == 8) check("fill.ready_after_8", 32'(key_ready), 32'd0);
        end
        check_state("fill");
        cs_low();
        for (int i = 0; i < 8; i++) spi_byte(8'(8'h10 + i), 8, 1'b0, 8'h00);
        cs_high();
        check_state("drain");

        // Push into a full FIFO in the same cycle as a pop
        do_reset();
        for (int i = 0; i < 8; i++) push_key(8'(8'h50 + i));
        cs_low();
        spi_byte(8'h77, 8, 1'b1, 8'h40);
        cs_high();
        check_state("concurrent");
        cs_low();
        for (int i = 0; i < 8; i++) spi_byte(8'($urandom_range(0, 255)), 8, 1'b0, 8'h00);
        cs_high();
        check_state("concurrent_drain");

        // Abort after 5 bits
        do_reset();
        push_key(8'h33);
        cs_low();
        spi_byte(8'h99, 5, 1'b0, 8'h00);
        cs_high();
        check_state("abort");
        cs_low();
        spi_byte(8'h5A, 8, 1'b0, 8'h00);
        cs_high();
        check_state("after_abort");

        // Reset in the middle of a byte
        push_key(8'h55);
        cs_low();
        spi_byte(8'hC3, 3, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset.miso",     32'(miso),      32'd0);
        check("midreset.rx_byte",  32'(rx_byte),   32'd0);
        check("midreset.rx_dv",    32'(rx_dv),     32'd0);
        check("midreset.ready",    32'(key_ready), 32'd1);
        check("midreset.count",    32'(count),     32'd0);
        check("midreset.overflow", 32'(overflow),  32'd0);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        cs_low();
        spi_byte(8'h0F, 8, 1'b0, 8'h00);
        cs_high();
        push_key(8'h00);
        check_state("zero_push");

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int npush, nbytes;
            npush  = $urandom_range(0, 4);
            nbytes = $urandom_range(1, 3);
            for (int p = 0; p < npush; p++) begin
                logic [7:0] kb;
                kb = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) kb = 8'h00;
                push_key(kb);
            end
            cs_low();
            for (int n = 0; n < nbytes; n++) begin
                int nb;
                nb = 8;
                if (n == nbytes - 1 && $urandom_range(0, 5) == 0) nb = $urandom_range(1, 7);
                spi_byte(8'($urandom_range(0, 255)), nb, 1'b0, 8'h00);
            end
            cs_high();
            check_state("random");
        end

        repeat (20) @(negedge clk);
        check("pending_rx",   32'(exp_rx_q.size()),   32'd0);
        check("pending_miso", 32'(exp_miso_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_keyboard_responder.md
Name: spi_keyboard_responder

Overview:
SPI mode-0 slave that sits on the keyboard side of the display/keyboard SPI bus (selected by the controller's second chip select). It buffers key-event bytes produced by a local key scanner in a small FIFO. It shifts the oldest event out on MISO, one byte per 8 SCLK cycles, while the controller clocks the bus. When no event is pending it returns the "no event" byte 0x00. It also captures the byte arriving on MOSI and presents it locally as a command strobe.

Parameters:
FIFO_DEPTH, 8, key-event FIFO entries; power of two, ≥2
IDLE_BYTE, 8'h00, byte shifted out when FIFO empty ("no event")

Ports:
i_Clk  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous active-high reset
i_SPI_Clk  in  1  SCLK from master, asynchronous to i_Clk
i_SPI_MOSI  in  1  MOSI from master
i_SPI_CS_n  in  1  chip select, active low
o_SPI_MISO  out  1  MISO to master
i_Key_Byte  in  8  key event from scanner
i_Key_Valid  in  1  push strobe for i_Key_Byte
o_Key_Ready  out  1  FIFO not full
o_RX_Byte  out  8  last complete MOSI byte
o_RX_DV  out  1  1-cycle strobe: o_RX_Byte updated
o_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_Overflow  out  1  sticky: push dropped because FIFO full

Behaviour:
- Reset: i_Reset is synchronous and active-high. During reset, all outputs take these values: o_SPI_MISO=0, o_RX_Byte=0, o_RX_DV=0, o_Key_Ready=1, o_Count=0, o_Overflow=0. Reset also empties the FIFO, clears the bit counter and forces state IDLE. Reset mid-transfer aborts the transfer with no pop.
- Synchronisers: SCLK, MOSI and CS_n each pass through 2-FF synchronisers. Edges are detected on the synchronised signals (3rd flop used for edge compare).
- Timing requirement: SCLK half-period ≥4 i_Clk cycles. The CS_n fall must precede the first SCLK rise by ≥4 i_Clk cycles.
- States: IDLE (CS_n high) and ACTIVE (CS_n low).
- IDLE→ACTIVE on synchronised CS_n fall:
  - Load the TX shift register with the FIFO head, or IDLE_BYTE if the FIFO is empty.
  - Set loaded_from_fifo accordingly.
  - Drive o_SPI_MISO = bit7 in the same cycle the load registers.
  - Clear the bit counter to 0.
- SCLK rise while ACTIVE:
  - Shift synchronised MOSI into the RX shift register, MSB first.
  - Increment the bit counter.
- SCLK fall while ACTIVE, bit counter 1..7: drive the next TX bit.
- 8th SCLK rise:
  - o_RX_Byte ← assembled byte; o_RX_DV=1 for exactly one cycle.
  - If loaded_from_fifo, pop the FIFO in that cycle.
  - Reset the bit counter to 0 and set the reload flag.
- SCLK fall with reload flag set (multi-byte transaction):
  - Load the new head, or IDLE_BYTE; drive its bit7; clear the reload flag.
- ACTIVE→IDLE on synchronised CS_n rise, at any bit count:
  - Partial byte discarded: no o_RX_DV, no pop.
  - o_SPI_MISO=0 within 1 cycle; bit counter cleared.
- FIFO push:
  - i_Key_Valid=1 and not full: write, o_Count+1.
  - Push of 8'h00 ignored (reserved as "no event").
  - Push when full: dropped and o_Overflow←1; it stays set until reset.
- Push and pop in the same cycle: both occur, o_Count unchanged; this is legal even when full.
- Pop never occurs when empty, because loaded_from_fifo=0.
- Pointers wrap modulo FIFO_DEPTH. o_Count ranges 0..FIFO_DEPTH. o_Key_Ready = (o_Count != FIFO_DEPTH), registered.
- Latency: a pushed byte is eligible for the next TX load one cycle after the push.

Decomposition:
- Shared package holds:
  - KEY_NO_EVENT = 8'h00, also used by the controller, which treats 0x00 as no event.
  - SPI_MODE = 0.
  - MIN_HALF_BIT_CLKS = 4.
- Sub-module key_event_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by depth. The SPI shifter and FSM stay in the top module.

Test Plan:
- Idle read: FIFO empty, master reads 1 byte with MOSI=0xA5 → MISO returns 0x00; o_RX_Byte=0xA5 with one o_RX_DV pulse; o_Count stays 0.
- Single event: push 0x1C, then master reads 2 bytes in one CS window → returns 0x1C then 0x00; o_Count goes 1→0 at the 8th rise.
- Fill/overflow (DEPTH=8): push 0x01..0x09 → 0x09 dropped; o_Overflow=1; o_Key_Ready=0 after 8 pushes; 8 reads return 0x01..0x08 in order.
- Concurrent: FIFO full; push 0x40 in the same cycle as a pop at the 8th rise → o_Count stays 8; o_Overflow stays 0; 0x40 read last.
- Abort: CS_n raised after 5 bits while sending 0x33 → no o_RX_DV, o_Count unchanged, MISO=0; the next transaction returns 0x33.
- Reset mid-byte: assert i_Reset at bit 3 → all outputs at reset values; the next read returns 0x00; zero-byte push (0x00) leaves o_Count=0.
